// File: rtl/ysyx_24100029_pkg.sv
// Shared types for the IDU->EXU issue controller: FSM states, stall reasons, register count.
package ysyx_24100029_pkg;

    localparam int REG_NUM = 32;
    localparam int OUT_W   = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SR_NONE = 2'd0,
        SR_RAW  = 2'd1,
        SR_WAW  = 2'd2,
        SR_SER  = 2'd3
    } stall_reason_e;

endpackage

// File: rtl/ysyx_24100029_scoreboard.sv
// Pending-load scoreboard: busy[31:1] with same-cycle writeback bypass on the lookups.
module ysyx_24100029_scoreboard
    import ysyx_24100029_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [REG_NUM-1:1] busy_q;
    logic [REG_NUM-1:1] set_vec;
    logic [REG_NUM-1:1] clear_vec;
    logic [REG_NUM-1:0] eff_busy;

    always_comb begin
        set_vec   = '0;
        clear_vec = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            set_vec[i]   = set_en && (set_rd == 5'(i));
            clear_vec[i] = clr_en && (clr_rd == 5'(i));
        end
    end

    // x0 never becomes busy, so bit 0 of the lookup vector is a constant zero
    assign eff_busy = {busy_q & ~clear_vec, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= (busy_q & ~clear_vec) | set_vec;
    end

    assign rs1_busy = eff_busy[rs1];
    assign rs2_busy = eff_busy[rs2];
    assign rd_busy  = eff_busy[rd];

endmodule

// File: rtl/ysyx_24100029_issue_ctrl.sv
// Issue controller: load-use / WAW / full / serialize stalls with EXU bubble insertion.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module ysyx_24100029_issue_ctrl
    import ysyx_24100029_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDU_valid,
    input  logic [4:0]       IDU_rs1,
    input  logic [4:0]       IDU_rs2,
    input  logic             IDU_rs1_used,
    input  logic             IDU_rs2_used,
    input  logic [4:0]       IDU_rd,
    input  logic             IDU_R_Wen,
    input  logic             IDU_is_load,
    input  logic             IDU_serialize,
    input  logic             flush,
    input  logic             WBU_valid,
    input  logic [4:0]       WBU_rd,
    output logic             IDU_ready,
    output logic             EXU_bubble,
    output logic [1:0]       stall_reason,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] load_stalls
);

    state_e           state;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] eff_out;
    logic             rs1_busy, rs2_busy, rd_busy;
    logic             raw, waw, ser, fire, load_fire, wb_dec;

    ysyx_24100029_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire & IDU_is_load & IDU_R_Wen),
        .set_rd   (IDU_rd),
        .clr_en   (WBU_valid),
        .clr_rd   (WBU_rd),
        .rs1      (IDU_rs1),
        .rs2      (IDU_rs2),
        .rd       (IDU_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // A writeback this cycle already frees its LSU slot for the full and drain checks
    assign wb_dec  = WBU_valid && (outstanding != '0);
    assign eff_out = outstanding - OUT_W'(wb_dec);

    assign raw       = (IDU_rs1_used & rs1_busy) | (IDU_rs2_used & rs2_busy);
    assign waw       = IDU_is_load & (rd_busy | (eff_out == OUT_W'(MAX_OUTSTANDING)));
    assign ser       = IDU_serialize & (eff_out != '0);
    assign IDU_ready = IDU_valid & ~(raw | waw | ser) & ~flush;
    assign fire      = IDU_valid & IDU_ready;
    assign load_fire = fire & IDU_is_load;
    assign EXU_bubble = ~fire;

    always_comb begin
        stall_reason = SR_NONE;
        if (IDU_valid && !IDU_ready) begin
            if (raw)      stall_reason = SR_RAW;
            else if (waw) stall_reason = SR_WAW;
            else if (ser) stall_reason = SR_SER;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (load_fire && !wb_dec) begin
            outstanding <= outstanding + 1'b1;
        end else if (!load_fire && wb_dec) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else if (flush)
            state <= RUN;
        else if (IDU_valid && (raw || waw))
            state <= STALL;
        else if (IDU_valid && ser)
            state <= DRAIN;
        else
            state <= RUN;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert (!(WBU_valid && outstanding == '0));
    end
`endif

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, load_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            load_cnt  <= '0;
        end else begin
            if (IDU_valid && !IDU_ready && !flush)
                stall_cnt <= stall_cnt + 1'b1;
            if (state == RUN && IDU_valid && raw && !flush)
                load_cnt <= load_cnt + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt;
    assign load_stalls  = load_cnt;
`else
    assign stall_cycles = '0;
    assign load_stalls  = '0;
`endif

endmodule
